// File: rtl/dmem_bus_bridge_pkg.sv
// Shared types and constants for the dmem valid/ready bus bridge.
package dmem_bus_bridge_pkg;
  localparam int DBB_XLEN = 32;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} dbb_state_t;

  localparam logic [31:0] DBB_ERR_RDATA = 32'h0000_0000;
  localparam logic [3:0]  DBB_BE_ALL    = 4'b1111;
endpackage

// File: rtl/dmem_write_buffer.sv
// One-entry posted-write buffer: push captures a store, pop frees the entry once it is on the bus.
// A push and a pop in the same cycle leave the entry valid with the new contents.
module dmem_write_buffer
  import dmem_bus_bridge_pkg::*;
#(
  parameter int XLEN = DBB_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [3:0]      be_i,
  input  logic            pop_i,
  output logic            valid_o,
  output logic [XLEN-1:0] addr_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [3:0]      be_o
);
  logic            valid_q, valid_d;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [3:0]      be_q;

  always_comb begin
    valid_d = valid_q;
    if (pop_i)  valid_d = 1'b0;
    if (push_i) valid_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      valid_q <= valid_d;
      if (push_i) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        be_q    <= be_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign be_o    = be_q;
endmodule

// File: rtl/dmem_bus_bridge.sv
// Bridges the MEM stage's single-cycle dmem port onto a valid/ready request/response bus, one access
// in flight, with a timeout watchdog. DMEM_BUS_BRIDGE_WRITE_BUFFER_EN adds a posted-write buffer.
module dmem_bus_bridge
  import dmem_bus_bridge_pkg::*;
#(
  parameter int XLEN           = DBB_XLEN,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  input  logic [3:0]      dmem_byte_en,
  input  logic            dmem_wr_en,
  input  logic            dmem_rd_en,
  output logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic            bus_err,
  output logic            req_valid,
  input  logic            req_ready,
  output logic            req_we,
  output logic [XLEN-1:0] req_addr,
  output logic [XLEN-1:0] req_wdata,
  output logic [3:0]      req_be,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_rdata,
  input  logic            rsp_err
);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      be;
  } req_t;

  dbb_state_t      state_q;
  req_t            req_q, core_req, wb_req;
  logic            req_valid_q, bus_err_q, drain_q;
  logic [XLEN-1:0] rdata_q;
  logic [TMO_W-1:0] tmo_q;
  logic            core_acc, in_bus, tmo_hit, rsp_done, tmo_done, mem_stall_c;
  logic            wb_valid;
  logic [XLEN-1:0] wb_addr, wb_wdata;
  logic [3:0]      wb_be;
  logic            unused_addr_lsb;

  assign core_acc        = dmem_rd_en | dmem_wr_en;
  assign unused_addr_lsb = ^dmem_addr[1:0];
  assign core_req = '{we:    dmem_wr_en,
                      addr:  {dmem_addr[XLEN-1:2], 2'b00},
                      wdata: dmem_wdata,
                      be:    dmem_wr_en ? dmem_byte_en : DBB_BE_ALL};
  assign wb_req   = '{we: 1'b1, addr: wb_addr, wdata: wb_wdata, be: wb_be};

`ifdef DMEM_BUS_BRIDGE_WRITE_BUFFER_EN
  localparam bit WB_EN = 1'b1;
  logic wb_push, wb_pop;

  // Only capture when the buffer is empty; a full buffer forces the store to wait for the drain.
  assign wb_push = (state_q == IDLE) && !wb_valid && dmem_wr_en;
  assign wb_pop  = drain_q && (rsp_done || tmo_done);

  dmem_write_buffer #(.XLEN(XLEN)) u_wbuf (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wb_push),
    .addr_i  (core_req.addr),
    .wdata_i (core_req.wdata),
    .be_i    (core_req.be),
    .pop_i   (wb_pop),
    .valid_o (wb_valid),
    .addr_o  (wb_addr),
    .wdata_o (wb_wdata),
    .be_o    (wb_be)
  );
`else
  localparam bit WB_EN = 1'b0;
  assign wb_valid = 1'b0;
  assign wb_addr  = '0;
  assign wb_wdata = '0;
  assign wb_be    = '0;
`endif

  assign in_bus   = (state_q == REQ) || (state_q == WAIT_RSP);
  assign tmo_hit  = (tmo_q >= TMO_W'(TIMEOUT_CYCLES - 1));
  assign rsp_done = ((state_q == REQ) && req_ready && rsp_valid) ||
                    ((state_q == WAIT_RSP) && rsp_valid);
  // A handshake in the final watchdog cycle wins over the timeout.
  assign tmo_done = in_bus && tmo_hit && !rsp_done && !((state_q == REQ) && req_ready);

  always_comb begin
    mem_stall_c = 1'b0;
    unique case (state_q)
      IDLE:          mem_stall_c = core_acc && (wb_valid || !(WB_EN && dmem_wr_en));
      REQ, WAIT_RSP: mem_stall_c = drain_q ? core_acc : 1'b1;
      DONE:          mem_stall_c = 1'b0;
      default:       mem_stall_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      req_q       <= '0;
      req_valid_q <= 1'b0;
      rdata_q     <= '0;
      bus_err_q   <= 1'b0;
      tmo_q       <= '0;
      drain_q     <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (wb_valid) begin
            req_q       <= wb_req;
            req_valid_q <= 1'b1;
            drain_q     <= 1'b1;
            tmo_q       <= '0;
            state_q     <= REQ;
          end else if (core_acc && !(WB_EN && dmem_wr_en)) begin
            req_q       <= core_req;
            req_valid_q <= 1'b1;
            drain_q     <= 1'b0;
            tmo_q       <= '0;
            state_q     <= REQ;
          end
        end
        REQ, WAIT_RSP: begin
          if (rsp_done || tmo_done) begin
            req_valid_q <= 1'b0;
            bus_err_q   <= tmo_done || rsp_err;
            if (!req_q.we)
              rdata_q <= (tmo_done || rsp_err) ? XLEN'(DBB_ERR_RDATA) : rsp_rdata;
            // Background drains never owe the core a DONE cycle.
            state_q <= drain_q ? IDLE : DONE;
          end else begin
            if ((state_q == REQ) && req_ready) begin
              req_valid_q <= 1'b0;
              state_q     <= WAIT_RSP;
            end
            if (tmo_q != TMO_W'(TIMEOUT_CYCLES)) tmo_q <= tmo_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_rdata = rdata_q;
  assign mem_stall  = mem_stall_c;
  assign bus_err    = bus_err_q;
  assign req_valid  = req_valid_q;
  assign req_we     = req_q.we;
  assign req_addr   = req_q.addr;
  assign req_wdata  = req_q.wdata;
  assign req_be     = req_q.be;
endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge with a load-data/error scoreboard and a small bus responder.
module tb_dmem_bus_bridge;
  import dmem_bus_bridge_pkg::*;

  localparam int TMO = 8;
`ifdef DMEM_BUS_BRIDGE_WRITE_BUFFER_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_byte_en;
  logic        dmem_wr_en, dmem_rd_en, mem_stall, bus_err;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  dmem_bus_bridge #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_byte_en(dmem_byte_en),
    .dmem_wr_en(dmem_wr_en), .dmem_rd_en(dmem_rd_en), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .bus_err(bus_err),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_rdata = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
  endtask

  // Drives one core access and answers the bus: accept after rdy_dly valid cycles, respond rsp_dly
  // cycles after acceptance (negative = never). Returns after the cycle the stall is released.
  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int rdy_dly, input int rsp_dly, input logic [31:0] rdata,
                        input logic err, input int exp_stall, input bit chk_gap);
    int   vcnt = 0;
    int   acc_cyc = -1;
    int   stall = 0;
    int   cyc = 0;
    bit   done = 1'b0;
    bit   tmo;
    exp_t e;
    exp_t got;
    dmem_addr = addr; dmem_wdata = wdata; dmem_byte_en = be;
    dmem_wr_en = we; dmem_rd_en = !we;
    tmo = (rdy_dly < 0) || (rsp_dly < 0);
    if (!we) model_rdata = (err || tmo) ? DBB_ERR_RDATA : rdata;
    e.rdata = model_rdata;
    e.err   = (err || tmo) && !(WB && we && exp_stall == 0);
    sb.push_back(e);
    while (!done && cyc < 64) begin
      bus_idle();
      if (req_valid) begin
        if (rdy_dly >= 0 && vcnt >= rdy_dly) begin req_ready = 1'b1; acc_cyc = cyc; end
        vcnt++;
      end
      if (acc_cyc >= 0 && rsp_dly >= 0 && cyc == acc_cyc + rsp_dly) begin
        rsp_valid = 1'b1; rsp_rdata = rdata; rsp_err = err;
      end
      #1;
      if (!mem_stall) done = 1'b1;
      else begin
        stall++;
        if (req_valid && !(WB && we)) begin
          chk({tag, "_req_addr"}, req_addr, {addr[31:2], 2'b00});
          chk({tag, "_req_we"}, {31'b0, req_we}, {31'b0, we});
          chk({tag, "_req_be"}, {28'b0, req_be}, {28'b0, we ? be : 4'hF});
          if (we) chk({tag, "_req_wdata"}, req_wdata, wdata);
        end
        if (chk_gap && cyc == 1) chk({tag, "_no_gap"}, {31'b0, req_valid}, 32'd1);
        chk({tag, "_no_early_err"}, {31'b0, bus_err}, 32'd0);
        tick();
        cyc++;
      end
    end
    bus_idle();
    if (!done) chk({tag, "_stall_bound"}, 32'd0, 32'd1);
    got = sb.pop_front();
    chk({tag, "_stall_cycles"}, stall, exp_stall);
    chk({tag, "_rdata"}, dmem_rdata, got.rdata);
    chk({tag, "_bus_err"}, {31'b0, bus_err}, {31'b0, got.err});
    if (!WB) chk({tag, "_done_req_valid"}, {31'b0, req_valid}, 32'd0);
    tick();
    dmem_rd_en = 1'b0; dmem_wr_en = 1'b0;
    chk({tag, "_err_one_pulse"}, {31'b0, bus_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    dmem_addr = '0; dmem_wdata = '0; dmem_byte_en = '0; dmem_wr_en = 1'b0; dmem_rd_en = 1'b0;
    bus_idle();
    tick(); tick();
    chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_req_we", {31'b0, req_we}, 32'd0);
    chk("rst_req_addr", req_addr, 32'd0);
    chk("rst_req_wdata", req_wdata, 32'd0);
    chk("rst_req_be", {28'b0, req_be}, 32'd0);
    chk("rst_rdata", dmem_rdata, 32'd0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
    chk("rst_stall", {31'b0, mem_stall}, 32'd0);
    reset = 1'b1;
    tick();

    // 1: load, accepted and answered in the first REQ cycle
    access("t1_load", 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 32'hCAFE_F00D, 1'b0, 2, 1'b0);
    // 2: store held off by req_ready for 5 cycles, response one cycle after accept
    access("t2_store", 1'b1, 32'h0000_0204, 32'hDEAD_BEEF, 4'b0011, 5, 1, 32'h0, 1'b0,
           WB ? 0 : 8, 1'b0);
    // 3: load never accepted -> watchdog
    access("t3_tmo", 1'b0, 32'h0000_0180, 32'h0, 4'h0, -1, -1, 32'h0, 1'b0, TMO + 1, 1'b0);
    // 4: error response, then a back-to-back load with no bus gap
    access("t4_err", 1'b0, 32'h0000_010F, 32'h0, 4'h0, 0, 0, 32'h1234_5678, 1'b1, 2, 1'b0);
    access("t4_b2b", 1'b0, 32'h0000_0300, 32'h0, 4'h0, 0, 0, 32'h55AA_33CC, 1'b0, 2, 1'b1);

    // 5: reset while waiting for a response, then a stray response
    dmem_addr = 32'h0000_0208; dmem_rd_en = 1'b1;
    tick();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("t5_wait_stall", {31'b0, mem_stall}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t5_rst_req_valid", {31'b0, req_valid}, 32'd0);
    chk("t5_rst_req_addr", req_addr, 32'd0);
    chk("t5_rst_req_be", {28'b0, req_be}, 32'd0);
    chk("t5_rst_rdata", dmem_rdata, 32'd0);
    dmem_rd_en = 1'b0;
    #1;
    chk("t5_rst_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    reset = 1'b1;
    model_rdata = 32'h0;
    rsp_valid = 1'b1; rsp_rdata = 32'hBAD0_BAD0;
    tick();
    bus_idle();
    chk("t5_stray_rdata", dmem_rdata, 32'd0);
    chk("t5_stray_err", {31'b0, bus_err}, 32'd0);
    chk("t5_stray_req_valid", {31'b0, req_valid}, 32'd0);
    chk("t5_stray_stall", {31'b0, mem_stall}, 32'd0);
    access("t5_after", 1'b0, 32'h0000_020C, 32'h0, 4'h0, 0, 0, 32'h0F0F_1234, 1'b0, 2, 1'b0);

    // 6: two stores back-to-back
    access("t6_st0", 1'b1, 32'h0000_0400, 32'h1111_2222, 4'b1111, 0, 0, 32'h0, 1'b0,
           WB ? 0 : 2, 1'b0);
    access("t6_st1", 1'b1, 32'h0000_0500, 32'h3333_4444, 4'b1100, 0, 0, 32'h0, 1'b0, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
